// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : core_sequencer
//  Brief    : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//             Owns the PC, the instruction register, both memory handshakes
//             and the register-file write strobe; raises a sticky trap.
//  Revision : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic        dec_illegal,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_wb,
    input  logic        dec_redirect,
    input  logic [31:0] dec_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [2:0]  state_o,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] retired
);

    // The wait counter holds 0..TIMEOUT-1; the last value is the expiry cycle.
    localparam int c_TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] c_CAUSE_ILLEGAL   = 2'b01;
    localparam logic [1:0] c_CAUSE_MISALIGN  = 2'b10;
    localparam logic [1:0] c_CAUSE_TIMEOUT   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t               r_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_ir;
    logic [31:0]          r_retired;
    logic                 r_trap;
    logic [1:0]           r_cause;
    logic [c_TMO_W-1:0]   r_tmo;

    logic                 w_tmo_hit;
    logic                 w_misaligned;

    assign w_tmo_hit    = (r_tmo == c_TMO_LAST);
    assign w_misaligned = dec_redirect && (dec_target[1:0] != 2'b00);

    // Requests and the write strobe follow the state directly; reset masks
    // them so an in-flight handshake is dropped immediately.
    assign imem_req   = (r_state == S_FETCH) && !reset;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM) && !reset;
    assign dmem_we    = dmem_req && dec_store;
    assign rf_we      = (r_state == S_WB) && !reset && dec_wb && !dec_store && !w_misaligned;

    assign ir         = r_ir;
    assign pc         = r_pc;
    assign state_o    = r_state;
    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign retired    = r_retired;

    // Sequencer: state, PC, IR, retire count, trap flag and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
            r_tmo     <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // An ack on the expiry cycle still wins over the timeout.
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_tmo   <= '0;
                        r_state <= S_DECODE;
                    end else if (w_tmo_hit) begin
                        r_tmo   <= '0;
                        r_trap  <= 1'b1;
                        r_cause <= c_CAUSE_TIMEOUT;
                        r_state <= S_TRAP;
                    end else begin
                        r_tmo   <= r_tmo + c_TMO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        r_trap  <= 1'b1;
                        r_cause <= c_CAUSE_ILLEGAL;
                        r_state <= S_TRAP;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A decode claiming both load and store is malformed.
                    if (dec_load && dec_store) begin
                        r_trap  <= 1'b1;
                        r_cause <= c_CAUSE_ILLEGAL;
                        r_state <= S_TRAP;
                    end else if (dec_load || dec_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_tmo   <= '0;
                        r_state <= S_WB;
                    end else if (w_tmo_hit) begin
                        r_tmo   <= '0;
                        r_trap  <= 1'b1;
                        r_cause <= c_CAUSE_TIMEOUT;
                        r_state <= S_TRAP;
                    end else begin
                        r_tmo   <= r_tmo + c_TMO_W'(1);
                    end
                end
                S_WB: begin
                    // A misaligned redirect faults without retiring.
                    if (w_misaligned) begin
                        r_trap  <= 1'b1;
                        r_cause <= c_CAUSE_MISALIGN;
                        r_state <= S_TRAP;
                    end else begin
                        r_retired <= r_retired + 32'd1;
                        r_pc      <= dec_redirect ? dec_target : (r_pc + 32'd4);
                        r_state   <= S_FETCH;
                    end
                end
                S_TRAP: begin
                    // Parked until reset; cause, PC and IR stay frozen.
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_TRAP;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
